udma_eth_frame_cfg_seq: RTL and testbench

// Initiator side of the uDMA eth-frame configuration bus. Accepts one transfer command
// (direction, L2 start address, size, continuous), programs the channel's SADDR/SIZE/CFG

---
 rtl/udma_eth_frame_cfg_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_udma_eth_frame_cfg_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_eth_frame_cfg_seq.sv
// Purpose : uDMA eth-frame config-bus initiator. It programs SADDR/SIZE/CFG for one command and polls CFG until the transfer ends.
// Latency : with cfg_ready_i=1, the writes land on cycles 1..3 after accept. The first poll beat is at 4+POLL_INTERVAL. done_o follows the finishing beat by one cycle.
// Backpress: one outstanding request. Request fields are held until cfg_valid_o&cfg_ready_i. cmd_ready_o is high only in IDLE.
//
// Ports:
//   clk_i, rstn_i           clock, async active-low reset
//   cmd_*                   command handshake (valid/ready) and fields, latched on accept
//   abort_i                 abort pulse, honoured once any in-flight request completes
//   cfg_*                   config bus master (valid/ready, rwn, word address, wdata/rdata)
//   busy_o, done_o,         status: busy while not idle, 1-cycle done/timeout pulses,
//   timeout_o, status_o     last CFG word read
module udma_eth_frame_cfg_seq #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int POLL_INTERVAL  = 8,
    parameter int TIMEOUT_POLLS  = 1024
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_dir_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cmd_addr_i,
    input  logic [TRANS_SIZE-1:0]     cmd_size_i,
    input  logic                      cmd_cont_i,
    input  logic                      abort_i,
    output logic                      cfg_valid_o,
    output logic                      cfg_rwn_o,
    output logic [4:0]                cfg_addr_o,
    output logic [31:0]               cfg_data_o,
    input  logic [31:0]               cfg_data_i,
    input  logic                      cfg_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [31:0]               status_o
);

    localparam int WAIT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int POLL_W = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_INTERVAL - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(TIMEOUT_POLLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SADDR,
        S_WR_SIZE,
        S_WR_CFG,
        S_WAIT,
        S_POLL,
        S_CLR,
        S_DONE
    } state_t;

    state_t                state;
    logic                  dir_q;
    logic                  cont_q;
    logic [TRANS_SIZE-1:0] size_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [POLL_W-1:0]     poll_cnt;
    logic                  abort_pend;
    logic                  clr_timeout_q;

    logic       beat;
    logic       abort_req;
    logic       poll_finished;
    logic [4:0] base;
    logic       enter_clr;
    logic       enter_clr_timeout;

    assign beat          = cfg_valid_o & cfg_ready_i;
    // An abort seen while a request is still waiting for its beat is remembered
    // in abort_pend, so the request is never withdrawn.
    assign abort_req     = abort_i | abort_pend;
    // The channel is idle once both pending (bit 5) and enable (bit 4) read back as 0.
    assign poll_finished = ~cfg_data_i[5] & ~cfg_data_i[4];
    assign base          = dir_q ? 5'h04 : 5'h00;

    assign cmd_ready_o = (state == S_IDLE);
    assign busy_o      = (state != S_IDLE);

    // Decide when to divert into the CLR write. A finishing poll always goes
    // to DONE, even when an abort arrives in the same beat.
    always_comb begin
        enter_clr         = 1'b0;
        enter_clr_timeout = 1'b0;
        case (state)
            S_WR_SADDR, S_WR_SIZE, S_WR_CFG: begin
                enter_clr = beat & abort_req;
            end
            S_WAIT: begin
                enter_clr = abort_req;
            end
            S_POLL: begin
                if (beat && !poll_finished) begin
                    if (abort_req) begin
                        enter_clr = 1'b1;
                    end else if (poll_cnt == POLL_LAST) begin
                        enter_clr         = 1'b1;
                        enter_clr_timeout = 1'b1;
                    end
                end
            end
            default: begin
                enter_clr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= S_IDLE;
            dir_q         <= 1'b0;
            cont_q        <= 1'b0;
            size_q        <= '0;
            wait_cnt      <= '0;
            poll_cnt      <= '0;
            abort_pend    <= 1'b0;
            clr_timeout_q <= 1'b0;
            cfg_valid_o   <= 1'b0;
            cfg_rwn_o     <= 1'b0;
            cfg_addr_o    <= 5'h00;
            cfg_data_o    <= 32'h0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
            status_o      <= 32'h0;
        end else begin
            done_o    <= 1'b0;
            timeout_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    if (cmd_valid_i) begin
                        dir_q         <= cmd_dir_i;
                        cont_q        <= cmd_cont_i;
                        size_q        <= cmd_size_i;
                        poll_cnt      <= '0;
                        wait_cnt      <= '0;
                        clr_timeout_q <= 1'b0;
                        state         <= S_WR_SADDR;
                        cfg_valid_o   <= 1'b1;
                        cfg_rwn_o     <= 1'b0;
                        cfg_addr_o    <= cmd_dir_i ? 5'h04 : 5'h00;
                        cfg_data_o    <= 32'(cmd_addr_i);
                    end
                end

                S_WR_SADDR: begin
                    if (beat) begin
                        state      <= S_WR_SIZE;
                        cfg_addr_o <= base + 5'd1;
                        cfg_data_o <= 32'(size_q);
                    end else begin
                        abort_pend <= abort_req;
                    end
                end

                S_WR_SIZE: begin
                    if (beat) begin
                        state      <= S_WR_CFG;
                        cfg_addr_o <= base + 5'd2;
                        cfg_data_o <= {27'h0, 1'b1, 3'h0, cont_q};
                    end else begin
                        abort_pend <= abort_req;
                    end
                end

                S_WR_CFG: begin
                    if (beat) begin
                        cfg_valid_o <= 1'b0;
                        wait_cnt    <= '0;
                        if (cont_q) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        abort_pend <= abort_req;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt    <= '0;
                        state       <= S_POLL;
                        cfg_valid_o <= 1'b1;
                        cfg_rwn_o   <= 1'b1;
                        cfg_addr_o  <= base + 5'd2;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_POLL: begin
                    if (beat) begin
                        status_o    <= cfg_data_i;
                        cfg_valid_o <= 1'b0;
                        if (poll_finished) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            state    <= S_WAIT;
                        end
                    end else begin
                        abort_pend <= abort_req;
                    end
                end

                S_CLR: begin
                    abort_pend <= 1'b0;
                    if (beat) begin
                        cfg_valid_o <= 1'b0;
                        timeout_o   <= clr_timeout_q;
                        state       <= S_IDLE;
                    end
                end

                S_DONE: begin
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // The CLR request overrides whatever the state arm scheduled.
            // It writes clr=1, en=0 to the channel CFG register.
            if (enter_clr) begin
                state         <= S_CLR;
                cfg_valid_o   <= 1'b1;
                cfg_rwn_o     <= 1'b0;
                cfg_addr_o    <= base + 5'd2;
                cfg_data_o    <= 32'h0000_0040;
                clr_timeout_q <= enter_clr_timeout;
                abort_pend    <= 1'b0;
                wait_cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_udma_eth_frame_cfg_seq.sv
module tb_udma_eth_frame_cfg_seq;

    localparam int PI = 3;
    localparam int TP = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_dir_i;
    logic [11:0] cmd_addr_i;
    logic [15:0] cmd_size_i;
    logic        cmd_cont_i;
    logic        abort_i;
    logic        cfg_valid_o;
    logic        cfg_rwn_o;
    logic [4:0]  cfg_addr_o;
    logic [31:0] cfg_data_o;
    logic [31:0] cfg_data_i;
    logic        cfg_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] status_o;

    udma_eth_frame_cfg_seq #(
        .L2_AWIDTH_NOAL(12),
        .TRANS_SIZE    (16),
        .POLL_INTERVAL (PI),
        .TIMEOUT_POLLS (TP)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_dir_i  (cmd_dir_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_size_i (cmd_size_i),
        .cmd_cont_i (cmd_cont_i),
        .abort_i    (abort_i),
        .cfg_valid_o(cfg_valid_o),
        .cfg_rwn_o  (cfg_rwn_o),
        .cfg_addr_o (cfg_addr_o),
        .cfg_data_o (cfg_data_o),
        .cfg_data_i (cfg_data_i),
        .cfg_ready_i(cfg_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .status_o   (status_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // kind: 0 write beat, 1 read beat, 2 done_o pulse, 3 timeout_o pulse.
    // cyc < 0 means the cycle is not checked.
    typedef struct packed {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];
    int          rd_beats     = 0;
    int          rdy_mode     = 0;
    int          stall_cnt    = 0;
    logic [31:0] model_status = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int k, input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Reference model: the bus transactions and pulses that one command should produce.
    // k is the number of not-finished polls before the finishing poll; k >= TP means timeout.
    task automatic model(input logic dir, input logic [11:0] a, input logic [15:0] s,
                         input logic cont, input int k, input int acc, input bit timed);
        logic [4:0]  b;
        logic [31:0] val;
        int          n;
        int          last;
        b = dir ? 5'h04 : 5'h00;
        push_exp(0, b,        {20'h0, a},             timed ? acc + 1 : -1);
        push_exp(0, b + 5'd1, {16'h0, s},             timed ? acc + 2 : -1);
        push_exp(0, b + 5'd2, 32'h10 | {31'h0, cont}, timed ? acc + 3 : -1);
        if (cont) begin
            push_exp(2, 5'h0, model_status, timed ? acc + 4 : -1);
        end else begin
            n   = (k >= TP) ? TP : k + 1;
            val = 32'h0;
            for (int i = 0; i < n; i++) begin
                if (i < k) begin
                    val = ($urandom & 32'hFFFF_FFCF) | (32'h10 << $urandom_range(0, 1));
                    if ($urandom_range(0, 1) == 1) val = val | 32'h30;
                end else begin
                    val = $urandom & 32'hFFFF_FFCF;
                end
                rsp_q.push_back(val);
                push_exp(1, b + 5'd2, 32'h0, timed ? acc + 4 + PI + i * (PI + 1) : -1);
            end
            last         = acc + 4 + PI + (n - 1) * (PI + 1);
            model_status = val;
            if (k >= TP) begin
                push_exp(0, b + 5'd2, 32'h40, timed ? last + 1 : -1);
                push_exp(3, 5'h0, val, timed ? last + 2 : -1);
            end else begin
                push_exp(2, 5'h0, val, timed ? last + 1 : -1);
            end
        end
    endtask

    // Config slave: read data indexed by completed read beats.
    // Ready is chosen per mode just after each clock edge.
    initial begin
        cfg_ready_i = 1'b0;
        cfg_data_i  = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            cfg_data_i = (rd_beats < rsp_q.size()) ? rsp_q[rd_beats] : 32'h30;
            case (rdy_mode)
                0: cfg_ready_i = 1'b1;
                1: cfg_ready_i = ($urandom_range(0, 2) != 0);
                3: begin
                    if (cfg_valid_o && cfg_addr_o[1:0] == 2'd0) stall_cnt = 0;
                    if (cfg_valid_o && !cfg_rwn_o && cfg_addr_o[1:0] == 2'd1 && stall_cnt < 3) begin
                        cfg_ready_i = 1'b0;
                        stall_cnt++;
                    end else begin
                        cfg_ready_i = 1'b1;
                    end
                end
                4: cfg_ready_i = !cfg_rwn_o;
                default: cfg_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: compares every beat and pulse against the scoreboard.
    // It also checks that a stalled request is held stable.
    initial begin
        logic        pv;
        logic [5:0]  pra;
        logic [31:0] pd;
        logic        rdy_chk;
        exp_t        e;
        pv      = 1'b0;
        pra     = 6'h0;
        pd      = 32'h0;
        rdy_chk = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                pv      = 1'b0;
                rdy_chk = 1'b0;
                continue;
            end
            if (rdy_chk) begin
                check("cmd_ready_after_done", cmd_ready_o, 1);
                rdy_chk = 1'b0;
            end
            if (pv) begin
                check("hold_valid", cfg_valid_o, 1);
                check("hold_rwn_addr", {cfg_rwn_o, cfg_addr_o}, pra);
                check("hold_data", cfg_data_o, pd);
            end
            pv  = cfg_valid_o && !cfg_ready_i;
            pra = {cfg_rwn_o, cfg_addr_o};
            pd  = cfg_data_o;
            if (cfg_valid_o && cfg_ready_i) begin
                if (cfg_rwn_o) rd_beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_addr", {cfg_rwn_o, cfg_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_kind", cfg_rwn_o ? 1 : 0, e.kind);
                    check("beat_addr", cfg_addr_o, e.addr);
                    if (!cfg_rwn_o) check("beat_wdata", cfg_data_o, e.data);
                    if (e.cyc >= 0) check("beat_cycle", cyc, e.cyc);
                end
            end
            if (done_o || timeout_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {done_o, timeout_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", done_o ? 2 : 3, e.kind);
                    check("pulse_both", done_o & timeout_o, 0);
                    check("pulse_status", status_o, e.data);
                    if (e.cyc >= 0) check("pulse_cycle", cyc, e.cyc);
                    if (done_o) begin
                        check("done_cmd_ready_low", cmd_ready_o, 0);
                        rdy_chk = 1'b1;
                    end
                end
            end
        end
    end

    // Present a command at a falling edge. Returns the accept cycle, leaving
    // cmd_valid_i high until release_cmd.
    task automatic send_cmd(input logic dir, input logic [11:0] a, input logic [15:0] s,
                            input logic c, output int acc);
        int n;
        n           = 0;
        cmd_dir_i   = dir;
        cmd_addr_i  = a;
        cmd_size_i  = s;
        cmd_cont_i  = c;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("cmd_accept", cmd_ready_o, 1);
        acc = cyc;
    endtask

    // Drop valid and scramble the fields; the DUT must use its latched copies.
    task automatic release_cmd();
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_dir_i   = 1'($urandom);
        cmd_addr_i  = 12'($urandom);
        cmd_size_i  = 16'($urandom);
        cmd_cont_i  = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk_i);
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clk_i);
        check("idle_busy", busy_o, 0);
        check("idle_cmd_ready", cmd_ready_o, 1);
    endtask

    task automatic run_std(input logic dir, input logic [11:0] a, input logic [15:0] s,
                           input logic cont, input int k, input bit timed);
        int acc;
        send_cmd(dir, a, s, cont, acc);
        model(dir, a, s, cont, k, acc, timed);
        release_cmd();
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
        $fatal(1);
    end

    initial begin
        int          acc;
        int          n;
        logic        dir;
        logic [11:0] a;
        logic [15:0] s;
        cmd_valid_i = 1'b0;
        cmd_dir_i   = 1'b0;
        cmd_addr_i  = 12'h0;
        cmd_size_i  = 16'h0;
        cmd_cont_i  = 1'b0;
        abort_i     = 1'b0;
        rstn_i      = 1'b0;

        repeat (3) @(negedge clk_i);
        check("rst_cfg_valid", cfg_valid_o, 0);
        check("rst_cfg_rwn", cfg_rwn_o, 0);
        check("rst_cfg_addr", cfg_addr_o, 0);
        check("rst_cfg_data", cfg_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_status", status_o, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("rst_cmd_ready", cmd_ready_o, 1);

        // An abort in IDLE is ignored.
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        @(negedge clk_i);
        check("abort_idle_busy", busy_o, 0);

        // RX command with exact timing, then a TX command with two pending polls.
        rdy_mode = 0;
        run_std(1'b0, 12'h123, 16'h0040, 1'b0, 0, 1'b1);
        run_std(1'b1, 12'hABC, 16'h0100, 1'b0, 2, 1'b1);
        // Poll timeout, then a continuous command.
        run_std(1'b0, 12'h010, 16'h0008, 1'b0, TP, 1'b1);
        run_std(1'b1, 12'hFFF, 16'hFFFF, 1'b1, 0, 1'b1);

        // WR_SIZE stalled for three cycles.
        rdy_mode = 3;
        run_std(1'b1, 12'h456, 16'h1234, 1'b0, 1, 1'b0);

        // Abort during WAIT: CLR write only, no pulse.
        rdy_mode = 0;
        send_cmd(1'b0, 12'h321, 16'h0020, 1'b0, acc);
        push_exp(0, 5'h00, 32'h321, acc + 1);
        push_exp(0, 5'h01, 32'h020, acc + 2);
        push_exp(0, 5'h02, 32'h010, acc + 3);
        push_exp(0, 5'h02, 32'h040, -1);
        release_cmd();
        while (cyc < acc + 5) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        drain();

        // Abort while WR_SIZE is stalled: the stalled write completes, then CLR.
        rdy_mode = 3;
        send_cmd(1'b1, 12'h077, 16'h0777, 1'b0, acc);
        push_exp(0, 5'h04, 32'h077, -1);
        push_exp(0, 5'h05, 32'h777, -1);
        push_exp(0, 5'h06, 32'h040, -1);
        release_cmd();
        while (cyc < acc + 3) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        drain();

        // Randomized commands, with random slave backpressure on some of them.
        for (int i = 0; i < 24; i++) begin
            rdy_mode = $urandom_range(0, 1);
            dir      = 1'($urandom);
            a        = 12'($urandom);
            s        = 16'($urandom);
            run_std(dir, a, s, ($urandom_range(0, 3) == 0), $urandom_range(0, TP), (rdy_mode == 0));
        end

        // Reset while a poll read is stalled on the bus.
        rdy_mode = 4;
        send_cmd(1'b0, 12'h555, 16'h0055, 1'b0, acc);
        push_exp(0, 5'h00, 32'h555, acc + 1);
        push_exp(0, 5'h01, 32'h055, acc + 2);
        push_exp(0, 5'h02, 32'h010, acc + 3);
        release_cmd();
        n = 0;
        while (!(cfg_valid_o && cfg_rwn_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("poll_request_seen", cfg_valid_o & cfg_rwn_o, 1);
        check("writes_before_reset", exp_q.size(), 0);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_cfg_valid", cfg_valid_o, 0);
        check("mid_rst_cfg_rwn", cfg_rwn_o, 0);
        check("mid_rst_cfg_addr", cfg_addr_o, 0);
        check("mid_rst_cfg_data", cfg_data_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_status", status_o, 0);
        repeat (3) @(negedge clk_i);
        check("mid_rst_no_traffic", cfg_valid_o, 0);
        rstn_i = 1'b1;
        model_status = 32'h0;
        @(negedge clk_i);
        check("post_rst_cmd_ready", cmd_ready_o, 1);
        check("post_rst_done", done_o | timeout_o, 0);
        exp_q.delete();

        rdy_mode = 0;
        run_std(1'b1, 12'h0AA, 16'h00AA, 1'b0, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
